// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - single-master I2C controller: one START/addr/data/STOP transaction per command
module i2c_master #(
    parameter int DIV = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       SCL,
    inout  wire        SDA
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_MACK, S_STOP
    } state_t;

    localparam logic [15:0] QMAX = 16'(DIV - 1);

    state_t      state;
    logic [15:0] qcnt;
    logic [1:0]  q;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic [7:0]  tx_byte;
    logic        rw_q;
    logic        sda_s;
    logic        sda_oe;
    logic        sda_in;
    logic        tick;

    // Open-drain data line: only ever pulled low, released otherwise.
    assign SDA    = sda_oe ? 1'b0 : 1'bz;
    assign sda_in = SDA;
    assign tick   = (qcnt == QMAX);

    // Transaction sequencer: quarter/slot timing, shifting, sampling and status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            qcnt    <= 16'd0;
            q       <= 2'd0;
            bit_cnt <= 3'd0;
            shreg   <= 8'd0;
            tx_byte <= 8'd0;
            rw_q    <= 1'b0;
            sda_s   <= 1'b1;
            rx_data <= 8'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                qcnt    <= 16'd0;
                q       <= 2'd0;
                bit_cnt <= 3'd0;
                if (start) begin
                    shreg   <= {addr, rw};
                    tx_byte <= tx_data;
                    rw_q    <= rw;
                    ack_err <= 1'b0;
                    busy    <= 1'b1;
                    state   <= S_START;
                end
            end else if (!tick) begin
                qcnt <= qcnt + 16'd1;
            end else begin
                qcnt <= 16'd0;
                q    <= q + 2'd1;
                // End of q2: SCL is still high, the line is stable.
                if (q == 2'd2) begin
                    sda_s <= sda_in;
                    if (state == S_RDATA)
                        shreg <= {shreg[6:0], sda_in};
                end
                // End of q3: the bit slot is complete.
                if (q == 2'd3) begin
                    case (state)
                        S_START: state <= S_ADDR;
                        S_ADDR, S_WDATA: begin
                            shreg   <= {shreg[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                state <= (state == S_ADDR) ? S_AACK : S_WACK;
                        end
                        S_AACK: begin
                            if (sda_s) begin
                                ack_err <= 1'b1;
                                state   <= S_STOP;
                            end else if (rw_q) begin
                                state <= S_RDATA;
                            end else begin
                                shreg <= tx_byte;
                                state <= S_WDATA;
                            end
                        end
                        S_WACK: begin
                            if (sda_s)
                                ack_err <= 1'b1;
                            state <= S_STOP;
                        end
                        S_RDATA: begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data <= shreg;
                                state   <= S_MACK;
                            end
                        end
                        S_MACK: state <= S_STOP;
                        S_STOP: begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    // Registered bus pins derived from the current state and quarter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            SCL    <= 1'b1;
            sda_oe <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    SCL    <= 1'b1;
                    sda_oe <= 1'b0;
                end
                S_START: begin
                    SCL    <= 1'b1;
                    sda_oe <= q[1];
                end
                S_ADDR, S_WDATA: begin
                    SCL    <= q[0] ^ q[1];
                    sda_oe <= ~shreg[7];
                end
                S_MACK: begin
                    SCL    <= q[0] ^ q[1];
                    sda_oe <= 1'b1;
                end
                S_STOP: begin
                    SCL    <= (q != 2'd0);
                    sda_oe <= ~q[1];
                end
                default: begin
                    SCL    <= q[0] ^ q[1];
                    sda_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - directed self-checking bench for i2c_master with a behavioural slave at 7'h55
module tb_i2c_master;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = 7'd0;
    logic [7:0] tx_data = 8'd0;
    logic [7:0] rx_data;
    logic       busy, done, ack_err, scl;
    wire        sda_bus;
    logic       sl_oe = 1'b0;

    pullup (sda_bus);
    assign sda_bus = sl_oe ? 1'b0 : 1'bz;

    i2c_master #(.DIV(DIV)) dut (
        .clk(clk), .reset(rst_n), .start(start), .rw(rw), .addr(addr),
        .tx_data(tx_data), .rx_data(rx_data), .busy(busy), .done(done),
        .ack_err(ack_err), .SCL(scl), .SDA(sda_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // bus monitor / slave state
    int         cyc = 0;
    int         done_cnt = 0, start_cnt = 0, stop_cnt = 0, scl_rise = 0;
    int         nbytes = 0, lg_cnt = 0;
    logic [7:0] lg_sh = 8'd0;
    logic [7:0] bus_byte [8];
    logic       bus_ack [8];
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    int         ph = 0, sbit = 0;
    logic [7:0] ssh = 8'd0, srd_byte = 8'd0, s_got = 8'd0;
    logic       s_rw = 1'b0, s_mack = 1'b1;

    // Bus values are stable across the posedge here; DUT pins change only after it.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            sl_oe  = 1'b0;
            ph     = 0;
            lg_cnt = 0;
        end else begin
            if (done) done_cnt++;
            if (prev_scl && scl && prev_sda && !sda_bus) begin
                start_cnt++;
                ph = 1; sbit = 0; lg_cnt = 0; sl_oe = 1'b0;
            end else if (prev_scl && scl && !prev_sda && sda_bus) begin
                stop_cnt++;
                ph = 0; sl_oe = 1'b0;
            end else if (!prev_scl && scl) begin
                scl_rise++;
                if (lg_cnt < 8) lg_sh = {lg_sh[6:0], sda_bus};
                lg_cnt++;
                if (lg_cnt == 8 && nbytes < 8) bus_byte[nbytes] = lg_sh;
                if (lg_cnt == 9) begin
                    if (nbytes < 8) bus_ack[nbytes] = sda_bus;
                    nbytes++;
                    lg_cnt = 0;
                end
                if (ph == 1 || ph == 3) begin
                    ssh = {ssh[6:0], sda_bus};
                    sbit++;
                end else if (ph == 6) begin
                    s_mack = sda_bus;
                end
            end else if (prev_scl && !scl) begin
                case (ph)
                    1: if (sbit == 8) begin
                        if (ssh[7:1] == 7'h55) begin
                            sl_oe = 1'b1; s_rw = ssh[0]; ph = 2;
                        end else begin
                            ph = 0;
                        end
                    end
                    2: begin
                        sbit = 0;
                        if (s_rw) begin sl_oe = !srd_byte[7]; ph = 5; end
                        else begin sl_oe = 1'b0; ph = 3; end
                    end
                    3: if (sbit == 8) begin s_got = ssh; sl_oe = 1'b1; ph = 4; end
                    4: begin sl_oe = 1'b0; ph = 0; end
                    5: begin
                        sbit++;
                        if (sbit < 8) sl_oe = !srd_byte[7 - sbit];
                        else begin sl_oe = 1'b0; ph = 6; end
                    end
                    6: ph = 0;
                    default: ph = 0;
                endcase
            end
        end
        prev_scl = scl;
        prev_sda = sda_bus;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        done_cnt = 0; start_cnt = 0; stop_cnt = 0; scl_rise = 0; nbytes = 0;
        s_got = 8'd0; s_mack = 1'b1;
    endtask

    task automatic start_txn(input logic r, input logic [6:0] a, input logic [7:0] d, output int t0);
        start = 1'b1; rw = r; addr = a; tx_data = d;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input string tag, input int t0, output int lat);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        lat = cyc - t0;
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    int t0, lat;

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_scl", {31'd0, scl}, 32'd1);
        chk("rst_sda", {31'd0, sda_bus}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ack_err", {31'd0, ack_err}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // write 8'hA5 to 7'h55
        clear_mon();
        start_txn(1'b0, 7'h55, 8'hA5, t0);
        chk("wr_busy", {31'd0, busy}, 32'd1);
        wait_done("wr_done_seen", t0, lat);
        chk("wr_latency", lat, 320);
        chk("wr_busy_at_done", {31'd0, busy}, 32'd0);
        chk("wr_ack_err", {31'd0, ack_err}, 32'd0);
        chk("wr_addr_byte", {24'd0, bus_byte[0]}, 32'hAA);
        chk("wr_data_byte", {24'd0, bus_byte[1]}, 32'hA5);
        chk("wr_slave_got", {24'd0, s_got}, 32'hA5);
        @(negedge clk);
        chk("wr_done_pulse", {31'd0, done}, 32'd0);
        chk("wr_start_cnt", start_cnt, 1);
        chk("wr_stop_cnt", stop_cnt, 1);

        // read from 7'h55, slave returns 8'h3C
        clear_mon();
        srd_byte = 8'h3C;
        start_txn(1'b1, 7'h55, 8'h00, t0);
        wait_done("rd_done_seen", t0, lat);
        chk("rd_latency", lat, 320);
        chk("rd_rx_data", {24'd0, rx_data}, 32'h3C);
        chk("rd_ack_err", {31'd0, ack_err}, 32'd0);
        @(negedge clk);
        chk("rd_addr_byte", {24'd0, bus_byte[0]}, 32'hAB);
        chk("rd_bus_data", {24'd0, bus_byte[1]}, 32'h3C);
        chk("rd_master_ack", {31'd0, s_mack}, 32'd0);
        chk("rd_stop_cnt", stop_cnt, 1);

        // address NACK
        clear_mon();
        start_txn(1'b0, 7'h12, 8'h77, t0);
        wait_done("nack_done_seen", t0, lat);
        chk("nack_latency", lat, 176);
        chk("nack_ack_err", {31'd0, ack_err}, 32'd1);
        @(negedge clk);
        chk("nack_nbytes", nbytes, 1);
        chk("nack_ack_bit", {31'd0, bus_ack[0]}, 32'd1);
        chk("nack_stop_cnt", stop_cnt, 1);
        repeat (5) @(negedge clk);
        chk("nack_ack_err_held", {31'd0, ack_err}, 32'd1);

        // start while busy is ignored
        clear_mon();
        start_txn(1'b0, 7'h55, 8'h11, t0);
        repeat (9) @(negedge clk);
        start = 1'b1; rw = 1'b1; addr = 7'h12; tx_data = 8'h99;
        @(negedge clk);
        start = 1'b0;
        wait_done("dbl_done_seen", t0, lat);
        chk("dbl_latency", lat, 320);
        chk("dbl_ack_err", {31'd0, ack_err}, 32'd0);
        repeat (400) @(negedge clk);
        chk("dbl_done_cnt", done_cnt, 1);
        chk("dbl_start_cnt", start_cnt, 1);
        chk("dbl_slave_got", {24'd0, s_got}, 32'h11);

        // reset during WDATA bit 3
        clear_mon();
        start_txn(1'b0, 7'h55, 8'hC3, t0);
        repeat (213) @(negedge clk);
        chk("mid_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_scl", {31'd0, scl}, 32'd1);
        chk("mid_sda", {31'd0, sda_bus}, 32'd1);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_mon();
        start_txn(1'b0, 7'h55, 8'h5A, t0);
        wait_done("post_done_seen", t0, lat);
        chk("post_latency", lat, 320);
        chk("post_ack_err", {31'd0, ack_err}, 32'd0);
        @(negedge clk);
        chk("post_slave_got", {24'd0, s_got}, 32'h5A);

        // back-to-back write then read
        clear_mon();
        srd_byte = 8'hFF;
        start_txn(1'b0, 7'h55, 8'hFF, t0);
        wait_done("b2b_wr_done", t0, lat);
        start_txn(1'b1, 7'h55, 8'h00, t0);
        wait_done("b2b_rd_done", t0, lat);
        chk("b2b_rd_latency", lat, 320);
        chk("b2b_rx_data", {24'd0, rx_data}, 32'hFF);
        @(negedge clk);
        chk("b2b_slave_got", {24'd0, s_got}, 32'hFF);
        chk("b2b_start_cnt", start_cnt, 2);
        chk("b2b_stop_cnt", stop_cnt, 2);
        chk("b2b_scl_rise", scl_rise, 38);
        chk("b2b_nbytes", nbytes, 4);
        chk("b2b_rd_addr", {24'd0, bus_byte[2]}, 32'hAB);
        chk("b2b_done_cnt", done_cnt, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
